// File: rtl/axis_slice_array_mc.sv
// N_CH independent AXI4-Stream channels, each a chain of N_STAGES skid-buffer stages,
// with synchronous flush, per-channel occupancy and saturating stall counters.

module axis_slice_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d;
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         in_fire, out_fire;

    assign in_ready  = rdy_q & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_v_q & out_ready;
    assign out_valid = main_v_q;
    assign out_data  = main_q;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (!main_v_q || out_fire) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = in_fire;
                if (in_fire) main_d = in_data;
            end
        end else if (in_fire) begin
            skid_d   = in_data;
            skid_v_d = 1'b1;
        end
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
        // ready is a flop copy of "skid will be empty", so no ready path crosses stages
        rdy_d = ~skid_v_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b0;
            main_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= rdy_d;
            main_q   <= main_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end
endmodule

module axis_slice_chan #(
    parameter int W        = 8,
    parameter int N_STAGES = 2,
    parameter int CNT_BITS = 16,
    parameter int OCC_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [W-1:0]        s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [W-1:0]        m_data,
    output logic [OCC_BITS-1:0] occupancy,
    output logic [CNT_BITS-1:0] stall_cnt
);
    logic [CNT_BITS-1:0] stall_q, stall_d;

    generate
        if (N_STAGES == 0) begin : g_wire
            assign m_valid   = s_valid;
            assign s_ready   = m_ready;
            assign m_data    = s_data;
            assign occupancy = '0;
        end else begin : g_chain
            logic         vld [N_STAGES+1];
            logic         rdy [N_STAGES+1];
            logic [W-1:0] dat [N_STAGES+1];
            logic [OCC_BITS-1:0] occ_q, occ_d;
            logic s_fire, m_fire;

            assign vld[0]       = s_valid;
            assign dat[0]       = s_data;
            assign s_ready      = rdy[0];
            assign rdy[N_STAGES] = m_ready;
            assign m_valid      = vld[N_STAGES];
            assign m_data       = dat[N_STAGES];

            for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
                axis_slice_stage #(.W(W)) u_stage (
                    .clk      (clk),
                    .rst      (rst),
                    .flush    (flush),
                    .in_valid (vld[k]),
                    .in_ready (rdy[k]),
                    .in_data  (dat[k]),
                    .out_valid(vld[k+1]),
                    .out_ready(rdy[k+1]),
                    .out_data (dat[k+1])
                );
            end

            assign s_fire = s_valid & rdy[0];
            assign m_fire = vld[N_STAGES] & m_ready;

            always_comb begin
                occ_d = occ_q;
                case ({s_fire, m_fire})
                    2'b10:   occ_d = occ_q + OCC_BITS'(1);
                    2'b01:   occ_d = occ_q - OCC_BITS'(1);
                    default: occ_d = occ_q;
                endcase
                if (flush) occ_d = '0;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) occ_q <= '0;
                else     occ_q <= occ_d;
            end

            assign occupancy = occ_q;
        end
    endgenerate

    always_comb begin
        stall_d = stall_q;
        if (flush)
            stall_d = '0;
        else if (m_valid && !m_ready && stall_q != '1)
            stall_d = stall_q + CNT_BITS'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
endmodule

module axis_slice_array_mc #(
    parameter int N_CH      = 3,
    parameter int DATA_BITS = 512,
    parameter int N_STAGES  = 2,
    parameter int CNT_BITS  = 16,
    parameter int OCC_BITS  = (N_STAGES == 0) ? 1 : $clog2(2*N_STAGES+1)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      flush,
    input  logic [N_CH-1:0]           s_axis_tvalid,
    output logic [N_CH-1:0]           s_axis_tready,
    input  logic [N_CH*DATA_BITS-1:0] s_axis_tdata,
    input  logic [N_CH*DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic [N_CH-1:0]           s_axis_tlast,
    output logic [N_CH-1:0]           m_axis_tvalid,
    input  logic [N_CH-1:0]           m_axis_tready,
    output logic [N_CH*DATA_BITS-1:0] m_axis_tdata,
    output logic [N_CH*DATA_BITS/8-1:0] m_axis_tkeep,
    output logic [N_CH-1:0]           m_axis_tlast,
    output logic [N_CH*OCC_BITS-1:0]  occupancy,
    output logic [N_CH*CNT_BITS-1:0]  stall_cnt
);
    localparam int KB = DATA_BITS / 8;
    // tdata/tkeep/tlast move through the stages as one word: {last, keep, data}
    localparam int W  = DATA_BITS + KB + 1;

    logic [N_CH-1:0][W-1:0] s_word, m_word;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign s_word[c] = {s_axis_tlast[c], s_axis_tkeep[c*KB +: KB],
                            s_axis_tdata[c*DATA_BITS +: DATA_BITS]};
        assign m_axis_tdata[c*DATA_BITS +: DATA_BITS] = m_word[c][DATA_BITS-1:0];
        assign m_axis_tkeep[c*KB +: KB]               = m_word[c][DATA_BITS +: KB];
        assign m_axis_tlast[c]                        = m_word[c][W-1];

        axis_slice_chan #(
            .W(W), .N_STAGES(N_STAGES), .CNT_BITS(CNT_BITS), .OCC_BITS(OCC_BITS)
        ) u_chan (
            .clk      (aclk),
            .rst      (areset),
            .flush    (flush),
            .s_valid  (s_axis_tvalid[c]),
            .s_ready  (s_axis_tready[c]),
            .s_data   (s_word[c]),
            .m_valid  (m_axis_tvalid[c]),
            .m_ready  (m_axis_tready[c]),
            .m_data   (m_word[c]),
            .occupancy(occupancy[c*OCC_BITS +: OCC_BITS]),
            .stall_cnt(stall_cnt[c*CNT_BITS +: CNT_BITS])
        );
    end
endmodule

// File: tb/tb_axis_slice_array_mc.sv
// Directed bench for axis_slice_array_mc: per-channel scoreboard queues, flush,
// back-pressure, stall saturation (second instance with 4-bit counters) and async reset.

module tb_axis_slice_array_mc;
    typedef logic [72:0] w_t;

    logic         aclk = 1'b0;
    logic         areset, flush;
    logic [2:0]   s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
    logic [191:0] s_tdata, m_tdata;
    logic [23:0]  s_tkeep, m_tkeep;
    logic [8:0]   occ;
    logic [47:0]  stall;

    logic [2:0]   s_tready4, m_tvalid4, m_tlast4;
    logic [191:0] m_tdata4;
    logic [23:0]  m_tkeep4;
    logic [8:0]   occ4;
    logic [11:0]  stall4;

    int nerr = 0, nchk = 0;
    int acc_cnt [3];
    w_t q0[$], q1[$], q2[$];

    always #5 aclk = ~aclk;

    axis_slice_array_mc #(.N_CH(3), .DATA_BITS(64), .N_STAGES(2), .CNT_BITS(16)) dut (
        .aclk(aclk), .areset(areset), .flush(flush),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .occupancy(occ), .stall_cnt(stall)
    );

    axis_slice_array_mc #(.N_CH(3), .DATA_BITS(64), .N_STAGES(2), .CNT_BITS(4)) dut4 (
        .aclk(aclk), .areset(areset), .flush(flush),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready4), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata4),
        .m_axis_tkeep(m_tkeep4), .m_axis_tlast(m_tlast4),
        .occupancy(occ4), .stall_cnt(stall4)
    );

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int c, input w_t w);
        case (c)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endtask

    task automatic sb_pop(input int c, output w_t w, output bit ok);
        ok = 1'b1;
        w  = '0;
        case (c)
            0:       if (q0.size() == 0) ok = 1'b0; else w = q0.pop_front();
            1:       if (q1.size() == 0) ok = 1'b0; else w = q1.pop_front();
            default: if (q2.size() == 0) ok = 1'b0; else w = q2.pop_front();
        endcase
    endtask

    task automatic sb_clear();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // One clock: observe handshakes mid-cycle, then return 1 time unit after the edge.
    task automatic cyc();
        w_t exp;
        bit ok;
        @(negedge aclk);
        for (int c = 0; c < 3; c++) begin
            if (m_tvalid[c] && m_tready[c]) begin
                sb_pop(c, exp, ok);
                if (!ok) chk($sformatf("unexpected_beat_ch%0d", c), w_t'(1), w_t'(0));
                else chk($sformatf("beat_ch%0d", c),
                         {m_tlast[c], m_tkeep[c*8 +: 8], m_tdata[c*64 +: 64]}, exp);
            end
            if (s_tvalid[c] && s_tready[c]) begin
                sb_push(c, {s_tlast[c], s_tkeep[c*8 +: 8], s_tdata[c*64 +: 64]});
                acc_cnt[c]++;
            end
        end
        if (flush) sb_clear();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_beat(input int c, input int n, input bit last);
        s_tdata[c*64 +: 64] = {8'(c), 24'h5a5a5a, 32'(n)};
        s_tkeep[c*8 +: 8]   = 8'($urandom);
        s_tlast[c]          = last;
    endtask

    initial begin
        areset = 1'b1; flush = 1'b0;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; m_tready = 3'b111;
        for (int c = 0; c < 3; c++) acc_cnt[c] = 0;

        // Reset state
        #12;
        chk("rst_s_tready", w_t'(s_tready), w_t'(0));
        chk("rst_m_tvalid", w_t'(m_tvalid), w_t'(0));
        chk("rst_occ", w_t'(occ), w_t'(0));
        chk("rst_stall", w_t'(stall), w_t'(0));
        chk("rst_m_tdata", w_t'(m_tdata[63:0]), w_t'(0));
        @(posedge aclk); #1;
        areset = 1'b0;
        #1;
        chk("rel_s_tready_before_edge", w_t'(s_tready), w_t'(0));
        cyc();
        chk("rel_s_tready_after_edge", w_t'(s_tready), w_t'(3'b111));

        // Single beat, 2-cycle latency, other channels idle
        s_tdata[63:0] = 64'hA5A5_A5A5_A5A5_A5A5; s_tkeep[7:0] = 8'hff; s_tlast[0] = 1'b1;
        s_tvalid = 3'b001;
        cyc();
        s_tvalid = '0;
        chk("lat_m_tvalid_c1", w_t'(m_tvalid), w_t'(0));
        cyc();
        chk("lat_m_tvalid_c2", w_t'(m_tvalid), w_t'(3'b001));
        cyc();
        chk("lat_q0_empty", w_t'(q0.size()), w_t'(0));

        // 100 back-to-back beats on every channel, output always ready
        for (int i = 0; i < 100; i++) begin
            for (int c = 0; c < 3; c++) set_beat(c, i, (i % 10) == 9);
            s_tvalid = 3'b111;
            cyc();
            if (i >= 1) begin
                chk($sformatf("b2b_m_tvalid_%0d", i), w_t'(m_tvalid), w_t'(3'b111));
                chk($sformatf("b2b_occ_%0d", i), w_t'(occ), w_t'(9'b010_010_010));
                chk($sformatf("b2b_s_tready_%0d", i), w_t'(s_tready), w_t'(3'b111));
            end
        end
        s_tvalid = '0;
        repeat (3) cyc();
        chk("b2b_drained", w_t'(q0.size() + q1.size() + q2.size()), w_t'(0));
        chk("b2b_occ_zero", w_t'(occ), w_t'(0));

        // ch1 blocked: capacity 4, stall counting, neighbours unaffected
        for (int c = 0; c < 3; c++) acc_cnt[c] = 0;
        m_tready = 3'b101;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < 3; c++) set_beat(c, 200 + i, 1'b0);
            s_tvalid = 3'b111;
            cyc();
            if (i >= 1) chk($sformatf("blk_neighbours_%0d", i), w_t'({m_tvalid[2], m_tvalid[0]}), w_t'(2'b11));
        end
        chk("blk_acc1", w_t'(acc_cnt[1]), w_t'(4));
        chk("blk_acc0_full_rate", w_t'(acc_cnt[0]), w_t'(10));
        chk("blk_s_tready1", w_t'(s_tready[1]), w_t'(0));
        chk("blk_occ1", w_t'(occ[5:3]), w_t'(4));
        chk("blk_stall1", w_t'(stall[31:16]), w_t'(8));
        cyc();
        chk("blk_stall1_inc", w_t'(stall[31:16]), w_t'(9));
        s_tvalid = '0;
        m_tready = 3'b111;
        repeat (6) cyc();
        chk("blk_drained", w_t'(q0.size() + q1.size() + q2.size()), w_t'(0));
        chk("blk_stall1_hold", w_t'(stall[31:16]), w_t'(9));

        // ch2 blocked 20 cycles: 16-bit counter reaches 20, 4-bit counter saturates at 15
        m_tready = 3'b011;
        set_beat(2, 300, 1'b1);
        s_tvalid = 3'b100;
        cyc();
        s_tvalid = '0;
        repeat (21) cyc();
        chk("sat_stall2_16b", w_t'(stall[47:32]), w_t'(20));
        chk("sat_stall2_4b", w_t'(stall4[11:8]), w_t'(15));
        m_tready = 3'b111;
        repeat (3) cyc();
        chk("sat_drained", w_t'(q2.size()), w_t'(0));

        // Flush with 3 beats held on ch0
        m_tready = 3'b110;
        for (int i = 0; i < 3; i++) begin
            set_beat(0, 400 + i, i == 2);
            s_tvalid = 3'b001;
            cyc();
        end
        chk("fl_occ0_loaded", w_t'(occ[2:0]), w_t'(3));
        set_beat(0, 403, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_s_tready_same_cycle", w_t'(s_tready), w_t'(0));
        cyc();
        flush = 1'b0;
        s_tvalid = '0;
        #1;
        chk("fl_m_tvalid", w_t'(m_tvalid), w_t'(0));
        chk("fl_occ", w_t'(occ), w_t'(0));
        chk("fl_stall", w_t'(stall), w_t'(0));
        m_tready = 3'b111;
        set_beat(0, 500, 1'b1);
        s_tvalid = 3'b001;
        cyc();
        s_tvalid = '0;
        chk("fl_new_c1", w_t'(m_tvalid), w_t'(0));
        cyc();
        chk("fl_new_c2", w_t'(m_tvalid), w_t'(3'b001));
        cyc();
        chk("fl_new_q0_empty", w_t'(q0.size()), w_t'(0));

        // Async reset mid-stream
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 3; c++) set_beat(c, 600 + i, 1'b0);
            s_tvalid = 3'b111;
            cyc();
        end
        #2;
        areset = 1'b1;
        #1;
        chk("ar_m_tvalid", w_t'(m_tvalid), w_t'(0));
        chk("ar_s_tready", w_t'(s_tready), w_t'(0));
        chk("ar_occ", w_t'(occ), w_t'(0));
        chk("ar_m_tdata", w_t'(m_tdata), w_t'(0));
        chk("ar_m_tlast", w_t'(m_tlast), w_t'(0));
        sb_clear();
        s_tvalid = '0;
        @(posedge aclk); #1;
        areset = 1'b0;
        #1;
        chk("ar_rel_s_tready_before", w_t'(s_tready), w_t'(0));
        cyc();
        chk("ar_rel_s_tready_after", w_t'(s_tready), w_t'(3'b111));
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("ar_no_stale_%0d", i), w_t'(m_tvalid), w_t'(0));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
